// File: rtl/lcd_write_engine.sv
// lcd_write_engine: HD44780-class LCD bus write engine.
// Each valid/ready handshake accepts one byte. The engine then drives the
// RS/RW/DB/E write waveform with programmable setup, enable-pulse, hold and
// execution times. Clear (0x01) and home (0x02) commands get the long wait.
//
// Optional feature macro: LCD_NIBBLE_MODE_EN
//   defined   - each byte is sent as two E pulses on lcd_db[7:4], high
//               nibble first; lcd_db[3:0] is held at 0.
//   undefined - 8-bit mode, one E pulse per byte.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   wr_valid  request present (source holds rs/data until accepted)
//   wr_ready  engine idle; accept when wr_valid && wr_ready
//   wr_rs     register select (0 command, 1 data)
//   wr_data   byte to write
//   wr_done   one-cycle pulse on the final exec-wait cycle
//   lcd_e     enable strobe
//   lcd_rs    RS pin
//   lcd_rw    RW pin, tied 0
//   lcd_db    data pins
module lcd_write_engine #(
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_EPW       = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db
);

    localparam int unsigned MAX_A = (T_SETUP > T_EPW)  ? T_SETUP : T_EPW;
    localparam int unsigned MAX_B = (T_HOLD  > T_EXEC) ? T_HOLD  : T_EXEC;
    localparam int unsigned MAX_C = (MAX_A   > MAX_B)  ? MAX_A   : MAX_B;
    localparam int unsigned MAX_T = (MAX_C > T_EXEC_LONG) ? MAX_C : T_EXEC_LONG;
    localparam int unsigned CNT_W = $clog2(MAX_T + 1);

    // Counter holds remaining cycles minus one; a state ends when it reads 0.
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EPW   = CNT_W'(T_EPW - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

    // Elaboration-time parameter bounds
    if (T_SETUP < 1) begin : g_bad_setup
        $error("lcd_write_engine: T_SETUP must be >= 1");
    end
    if (T_EPW < 1) begin : g_bad_epw
        $error("lcd_write_engine: T_EPW must be >= 1");
    end
    if (T_HOLD < 1) begin : g_bad_hold
        $error("lcd_write_engine: T_HOLD must be >= 1");
    end
    if (T_EXEC < 1) begin : g_bad_exec
        $error("lcd_write_engine: T_EXEC must be >= 1");
    end
    if (T_EXEC_LONG < T_EXEC) begin : g_bad_long
        $error("lcd_write_engine: T_EXEC_LONG must be >= T_EXEC");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_EHIGH = 3'd2,
        S_HOLD  = 3'd3,
        S_EXEC  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       db_q, db_d;
    logic             e_q, e_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             accept_c;
    logic             long_c;
`ifdef LCD_NIBBLE_MODE_EN
    logic             nib_q, nib_d;
`endif

    assign accept_c = (state_q == S_IDLE) && wr_valid;
    assign long_c   = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            db_q    <= 8'h00;
            e_q     <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
            nib_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            db_q    <= db_d;
            e_q     <= e_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef LCD_NIBBLE_MODE_EN
            nib_q   <= nib_d;
`endif
        end
    end

    // Next-state and counter reload on every state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
`ifdef LCD_NIBBLE_MODE_EN
        nib_d   = nib_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (wr_valid) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
`ifdef LCD_NIBBLE_MODE_EN
                    nib_d   = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_EHIGH;
                    cnt_d   = LD_EPW;
                end
            end
            S_EHIGH: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_EXEC;
                    cnt_d   = long_c ? LD_LONG : LD_EXEC;
`ifdef LCD_NIBBLE_MODE_EN
                    // First nibble done: go back for the low nibble, no exec
                    if (!nib_q) begin
                        state_d = S_SETUP;
                        cnt_d   = LD_SETUP;
                        nib_d   = 1'b1;
                    end
`endif
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next values, decoded from the upcoming state
    always_comb begin
        rs_d    = rs_q;
        data_d  = data_q;
        db_d    = db_q;
        e_d     = (state_d == S_EHIGH);
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_EXEC) && (cnt_d == '0);
        if (accept_c) begin
            rs_d   = wr_rs;
            data_d = wr_data;
`ifdef LCD_NIBBLE_MODE_EN
            db_d   = {wr_data[7:4], 4'h0};
`else
            db_d   = wr_data;
`endif
        end
`ifdef LCD_NIBBLE_MODE_EN
        if ((state_q == S_HOLD) && (cnt_q == '0) && !nib_q) begin
            db_d = {data_q[3:0], 4'h0};
        end
`endif
    end

    assign wr_ready = ready_q;
    assign wr_done  = done_q;
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_db   = db_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed self-checking bench for lcd_write_engine with
// T_SETUP=2, T_EPW=3, T_HOLD=2, T_EXEC=5, T_EXEC_LONG=20.
module tb_lcd_write_engine;

`ifdef LCD_NIBBLE_MODE_EN
    localparam int NIB = 1;
`else
    localparam int NIB = 0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_db;

    int checks = 0;
    int errors = 0;

    lcd_write_engine #(
        .T_SETUP    (2),
        .T_EPW      (3),
        .T_HOLD     (2),
        .T_EXEC     (5),
        .T_EXEC_LONG(20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_rs   (wr_rs),
        .wr_data (wr_data),
        .wr_done (wr_done),
        .lcd_e   (lcd_e),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_db  (lcd_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample point is the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at the sampling point of the acceptance cycle (cycle 0).
    // done_c is the 8-bit-mode done cycle; nibble mode adds 7 cycles.
    // From cycle nxt_from onward a new request (nrs, nd) is held on the bus.
    task automatic do_write(input logic rs, input logic [7:0] d, input int done_c8,
                            input int nxt_from, input logic nrs, input logic [7:0] nd);
        int         done_c;
        logic       exp_e;
        logic [7:0] exp_db;
        done_c   = done_c8 + 7 * NIB;
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        chk("ready_c0", wr_ready, 8'(1));
        chk("done_c0", wr_done, 8'(0));
        for (int c = 1; c <= done_c + 1; c++) begin
            step();
            exp_e = ((c >= 3) && (c <= 5)) || ((NIB == 1) && (c >= 10) && (c <= 12));
            if (NIB == 1) exp_db = (c <= 7) ? {d[7:4], 4'h0} : {d[3:0], 4'h0};
            else          exp_db = d;
            chk("lcd_e", lcd_e, 8'(exp_e));
            chk("lcd_db", lcd_db, exp_db);
            chk("lcd_rs", lcd_rs, 8'(rs));
            chk("lcd_rw", lcd_rw, 8'(0));
            chk("wr_done", wr_done, 8'(c == done_c));
            chk("wr_ready", wr_ready, 8'(c == done_c + 1));
            wr_valid = (nxt_from > 0) && (c >= nxt_from);
            if (wr_valid) begin
                wr_rs   = nrs;
                wr_data = nd;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_rs    = 1'b0;
        wr_data  = 8'h00;
        step();
        step();
        chk("rst_e", lcd_e, 8'(0));
        chk("rst_rs", lcd_rs, 8'(0));
        chk("rst_db", lcd_db, 8'h00);
        chk("rst_done", wr_done, 8'(0));
        chk("rst_ready", wr_ready, 8'(1));
        rst = 1'b0;
        step();
        chk("post_rst_ready", wr_ready, 8'(1));

        // 8-bit data write
        do_write(1'b1, 8'h41, 12, 0, 1'b0, 8'h00);
        // Clear/home get the long wait, other commands the normal one
        do_write(1'b0, 8'h01, 27, 0, 1'b0, 8'h00);
        do_write(1'b0, 8'h02, 27, 0, 1'b0, 8'h00);
        do_write(1'b0, 8'h00, 12, 0, 1'b0, 8'h00);
        do_write(1'b0, 8'h38, 12, 0, 1'b0, 8'h00);
        // Request held during EXEC is ignored, then accepted on the ready cycle
        do_write(1'b1, 8'h55, 12, 8 + 7 * NIB, 1'b0, 8'h42);
        do_write(1'b0, 8'h42, 12, 0, 1'b0, 8'h00);
        // Back-to-back with wr_valid kept high
        do_write(1'b1, 8'h48, 12, 1, 1'b1, 8'h49);
        do_write(1'b1, 8'h49, 12, 0, 1'b0, 8'h00);

        // Pins hold their last values while idle
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_db", lcd_db, (NIB == 1) ? 8'h90 : 8'h49);
            chk("idle_rs", lcd_rs, 8'(1));
            chk("idle_ready", wr_ready, 8'(1));
            chk("idle_done", wr_done, 8'(0));
        end

        // Reset during EHIGH
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h41;
        step();
        wr_valid = 1'b0;
        step();
        step();
        step();
        chk("pre_rst_e", lcd_e, 8'(1));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_e", lcd_e, 8'(0));
        chk("async_rst_db", lcd_db, 8'h00);
        chk("async_rst_ready", wr_ready, 8'(1));
        chk("async_rst_done", wr_done, 8'(0));
        step();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("abandon_done", wr_done, 8'(0));
            chk("abandon_ready", wr_ready, 8'(1));
            chk("abandon_e", lcd_e, 8'(0));
            chk("abandon_db", lcd_db, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
